// File: rtl/alu_toplevel_pkg.sv
// Shared definitions for the switch/button ALU: default widths, opcode
// encodings and the opcode-validity helper used by the debug flags.
package alu_toplevel_pkg;

   localparam int NB_DATA_DEF  = 8;
   localparam int NB_OP_DEF    = 6;
   localparam int NB_DEBUG_DEF = 4;
   localparam int OP_W         = 6;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 6'b100000,
      OP_SUB = 6'b100010,
      OP_AND = 6'b100100,
      OP_OR  = 6'b100101,
      OP_XOR = 6'b100110,
      OP_NOR = 6'b100111,
      OP_SRA = 6'b000011,
      OP_SRL = 6'b000010
   } op_e;

   function automatic logic is_valid_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
         default:                        is_valid_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_toplevel_alu.sv
// Purely combinational ALU: arithmetic, bitwise and shift operations on two
// operands; unsupported opcodes yield zero.
module alu
   import alu_toplevel_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_OP   = NB_OP_DEF
) (
   input  logic [NB_DATA-1:0] a,
   input  logic [NB_DATA-1:0] b,
   input  logic [NB_OP-1:0]   op,
   output logic [NB_DATA-1:0] result
);

   logic [OP_W-1:0] op_key;

   assign op_key = OP_W'(op);

   // NOTE: result gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      result = '0;
      case (op_key)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOR: result = ~(a | b);
         // >>> on a signed operand sign-fills even when b >= NB_DATA
         OP_SRA: result = $signed(a) >>> b;
         OP_SRL: result = a >> b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_toplevel.sv
// Board-level ALU wrapper: buttons latch the switch value into operand and
// opcode registers; LEDs show the result and which registers were loaded.
module alu_toplevel
   import alu_toplevel_pkg::*;
#(
   parameter int NB_DATA  = NB_DATA_DEF,
   parameter int NB_OP    = NB_OP_DEF,
   parameter int NB_DEBUG = NB_DEBUG_DEF
) (
   input  logic                i_clk,
   input  logic                i_btnU,
   input  logic [NB_DATA-1:0]  i_sw,
   input  logic                i_btnL,
   input  logic                i_btnR,
   input  logic                i_btnC,
   output logic [NB_DATA-1:0]  o_led,
   output logic [NB_DEBUG-1:0] o_debugled
);

   logic [NB_DATA-1:0] reg_a;
   logic [NB_DATA-1:0] reg_b;
   logic [NB_OP-1:0]   reg_op;
   logic               a_loaded;
   logic               b_loaded;
   logic               op_loaded;
   logic [3:0]         flags;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, which also makes simultaneous loads safe.
   always_ff @(posedge i_clk or posedge i_btnU) begin
      if (i_btnU) begin
         reg_a     <= '0;
         reg_b     <= '0;
         reg_op    <= '0;
         a_loaded  <= 1'b0;
         b_loaded  <= 1'b0;
         op_loaded <= 1'b0;
      end else begin
         if (i_btnL) begin
            reg_a    <= i_sw;
            a_loaded <= 1'b1;
         end
         if (i_btnR) begin
            reg_b    <= i_sw;
            b_loaded <= 1'b1;
         end
         if (i_btnC) begin
            reg_op    <= i_sw[NB_OP-1:0];
            op_loaded <= 1'b1;
         end
      end
   end

   alu #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP)
   ) u_alu (
      .a      (reg_a),
      .b      (reg_b),
      .op     (reg_op),
      .result (o_led)
   );

   // The reset value of reg_op is itself unsupported, so bit 3 waits for a load
   assign flags      = {op_loaded && !is_valid_op(OP_W'(reg_op)), op_loaded, b_loaded, a_loaded};
   assign o_debugled = NB_DEBUG'(flags);

endmodule

// File: tb/tb_alu_toplevel.sv
// Scoreboard bench for alu_toplevel: stimulus pushes hand-computed LED values,
// a negedge monitor pops and compares them against the outputs.
module tb_alu_toplevel;

   localparam int HALF = 5;

   typedef struct {
      logic [7:0] led;
      logic [3:0] dbg;
      string      name;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_btnU = 1'b0;
   logic [7:0] i_sw = '0;
   logic       i_btnL = 1'b0;
   logic       i_btnR = 1'b0;
   logic       i_btnC = 1'b0;
   logic [7:0] o_led;
   logic [3:0] o_debugled;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   alu_toplevel dut (
      .i_clk      (i_clk),
      .i_btnU     (i_btnU),
      .i_sw       (i_sw),
      .i_btnL     (i_btnL),
      .i_btnR     (i_btnR),
      .i_btnC     (i_btnC),
      .o_led      (o_led),
      .o_debugled (o_debugled)
   );

   always #HALF i_clk = ~i_clk;

   // Monitor: outputs are sampled on the falling edge, away from register updates
   always @(negedge i_clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         if (o_led !== e.led || o_debugled !== e.dbg) begin
            bad++;
            $display("FAIL %s: led=%h dbg=%b, expected led=%h dbg=%b",
                     e.name, o_led, o_debugled, e.led, e.dbg);
         end
      end
   end

   task automatic press(input logic l, input logic r, input logic c, input logic [7:0] sw);
      i_btnL = l;
      i_btnR = r;
      i_btnC = c;
      i_sw   = sw;
      @(posedge i_clk);
      #1;
      i_btnL = 1'b0;
      i_btnR = 1'b0;
      i_btnC = 1'b0;
   endtask

   task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      press(1'b1, 1'b0, 1'b0, a);
      press(1'b0, 1'b1, 1'b0, b);
      press(1'b0, 1'b0, 1'b1, op);
   endtask

   task automatic expect_out(input logic [7:0] led, input logic [3:0] dbg, input string name);
      exp_t e;
      e.led  = led;
      e.dbg  = dbg;
      e.name = name;
      sb.push_back(e);
      @(negedge i_clk);
      #1;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s: monitor did not consume entry, pending=%0d expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      // Reset pulse
      #2;
      i_btnU = 1'b1;
      #1;
      expect_out(8'h00, 4'b0000, "reset");
      i_btnU = 1'b0;

      press(1'b1, 1'b0, 1'b0, 8'hFF);
      expect_out(8'h00, 4'b0001, "only_a_loaded");
      press(1'b0, 1'b1, 1'b0, 8'hF0);
      press(1'b0, 1'b0, 1'b1, 8'h24);
      expect_out(8'hF0, 4'b0111, "and_ff_f0");

      load3(8'h7F, 8'h01, 8'h20);
      expect_out(8'h80, 4'b0111, "add_7f_01");
      load3(8'h00, 8'h01, 8'h22);
      expect_out(8'hFF, 4'b0111, "sub_00_01");
      load3(8'hFF, 8'h01, 8'h20);
      expect_out(8'h00, 4'b0111, "add_wrap");

      load3(8'h80, 8'h02, 8'h03);
      expect_out(8'hE0, 4'b0111, "sra_80_2");
      press(1'b0, 1'b0, 1'b1, 8'h02);
      expect_out(8'h20, 4'b0111, "srl_80_2");
      press(1'b0, 1'b1, 1'b0, 8'h09);
      expect_out(8'h00, 4'b0111, "srl_80_9");
      press(1'b0, 1'b0, 1'b1, 8'h03);
      expect_out(8'hFF, 4'b0111, "sra_80_9");

      press(1'b0, 1'b0, 1'b1, 8'h3F);
      expect_out(8'h00, 4'b1111, "bad_op");
      load3(8'h0F, 8'hF0, 8'h27);
      expect_out(8'h00, 4'b0111, "nor_0f_f0");
      press(1'b0, 1'b0, 1'b1, 8'h25);
      expect_out(8'hFF, 4'b0111, "or_0f_f0");
      press(1'b0, 1'b0, 1'b1, 8'h26);
      expect_out(8'hFF, 4'b0111, "xor_0f_f0");
      // Upper switch bits must not reach the opcode: E4 -> AND
      load3(8'h3C, 8'hF0, 8'hE4);
      expect_out(8'h30, 4'b0111, "op_upper_ignored");
      repeat (3) @(posedge i_clk);
      #1;
      expect_out(8'h30, 4'b0111, "persist");

      press(1'b1, 1'b1, 1'b0, 8'h05);
      press(1'b0, 1'b0, 1'b1, 8'h26);
      expect_out(8'h00, 4'b0111, "xor_same");
      press(1'b0, 1'b0, 1'b1, 8'h20);
      expect_out(8'h0A, 4'b0111, "add_05_05");

      // Mid-cycle reset: must clear before the next rising edge
      @(posedge i_clk);
      #2;
      i_btnU = 1'b1;
      #1;
      expect_out(8'h00, 4'b0000, "async_reset");

      // Buttons held during reset are ignored
      i_btnL = 1'b1;
      i_btnC = 1'b1;
      i_sw   = 8'h55;
      @(posedge i_clk);
      #1;
      expect_out(8'h00, 4'b0000, "reset_override");
      i_btnL = 1'b0;
      i_btnC = 1'b0;
      i_btnU = 1'b0;

      press(1'b1, 1'b1, 1'b1, 8'h20);
      expect_out(8'h40, 4'b0111, "all_three_add");
      load3(8'h55, 8'h11, 8'h20);
      expect_out(8'h66, 4'b0111, "add_55_11");

      repeat (2) @(posedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
